// File: rtl/t_ram_pkg.sv
// Shared definitions for the t_ram family: sequencer states, read-latency bounds
// and the depth helper used to size the array.
package t_ram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_e;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 4;

  function automatic int depth(input int aw);
    return 1 << aw;
  endfunction

endpackage

// File: rtl/t_ram_rd_pipe.sv
// Extra read-latency stages for t_ram_sdp: STAGES registers of valid+data, all
// asynchronously cleared. STAGES=0 is a straight wire.
module t_ram_rd_pipe #(
  parameter int DW     = 16,
  parameter int STAGES = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  output logic [DW-1:0] out_data
);

  generate
    if (STAGES == 0) begin : g_pass
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst;
      assign out_valid      = in_valid;
      assign out_data       = in_data;
    end else begin : g_stages
      logic [STAGES-1:0]         valid_q, valid_d;
      logic [STAGES-1:0][DW-1:0] data_q, data_d;

      always_comb begin
        valid_d[0] = in_valid;
        data_d[0]  = in_data;
        for (int i = 1; i < STAGES; i++) begin
          valid_d[i] = valid_q[i-1];
          data_d[i]  = data_q[i-1];
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          valid_q <= '0;
          data_q  <= '0;
        end else begin
          valid_q <= valid_d;
          data_q  <= data_d;
        end
      end

      assign out_valid = valid_q[STAGES-1];
      assign out_data  = data_q[STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/t_ram_sdp.sv
// Simple-dual-port scratch RAM with lane write enables, RD_LAT-cycle read and a
// clear sequencer. Define T_RAM_SDP_FWD_EN for write-first same-address reads.
module t_ram_sdp
  import t_ram_pkg::*;
#(
  parameter int DW     = 16,
  parameter int AW     = 4,
  parameter int LANES  = 2,
  parameter int RD_LAT = 1
) (
  input  logic             clk,
  input  logic             sys_rst,
  input  logic             clr_req,
  output logic             busy,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [LANES-1:0] wr_be,
  input  logic [DW-1:0]    wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [DW-1:0]    rd_data,
  output logic             rd_valid
);

  localparam int DEPTH = depth(AW);
  localparam int LW    = DW / LANES;

  generate
    if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
      $error("t_ram_sdp: RD_LAT out of range");
    end
    if (DW % LANES != 0) begin : g_bad_lanes
      $error("t_ram_sdp: DW must be a multiple of LANES");
    end
  endgenerate

  state_e        state_q, state_d;
  logic [AW-1:0] clr_cnt_q, clr_cnt_d;
  logic          idle, wr_ok, rd_ok;

  assign idle  = (state_q == IDLE);
  assign busy  = ~idle;
  assign wr_ok = idle & wr_en;
  assign rd_ok = idle & rd_en;

  // NOTE: every signal driven here gets a default first so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      CLEAR: begin
        clr_cnt_d = clr_cnt_q + AW'(1);
        if (clr_cnt_q == AW'(DEPTH - 1)) state_d = IDLE;
      end
      IDLE: begin
        if (clr_req) begin
          state_d   = CLEAR;
          clr_cnt_d = '0;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  logic [DW-1:0] ram [DEPTH];

  // NOTE: the array itself is not reset; the clear sequencer zeroes it after reset.
  always_ff @(posedge clk) begin
    if (!idle) begin
      ram[clr_cnt_q] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < LANES; i++) begin
        if (wr_be[i]) ram[wr_addr][i*LW +: LW] <= wr_data[i*LW +: LW];
      end
    end
  end

  logic [DW-1:0] rd_word;
  logic [DW-1:0] rd_data_d, rd_data_q;
  logic          rd_valid_d, rd_valid_q;

  always_comb begin
    rd_word = ram[rd_addr];
`ifdef T_RAM_SDP_FWD_EN
    if (wr_ok && (wr_addr == rd_addr)) begin
      for (int i = 0; i < LANES; i++) begin
        if (wr_be[i]) rd_word[i*LW +: LW] = wr_data[i*LW +: LW];
      end
    end
`endif
    rd_valid_d = rd_ok;
    rd_data_d  = rd_ok ? rd_word : '0;
  end

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  t_ram_rd_pipe #(
    .DW    (DW),
    .STAGES(RD_LAT - 1)
  ) u_rd_pipe (
    .clk      (clk),
    .rst      (sys_rst),
    .in_valid (rd_valid_q),
    .in_data  (rd_data_q),
    .out_valid(rd_valid),
    .out_data (rd_data)
  );

  logic unused_wr_ok;
  assign unused_wr_ok = wr_ok;

endmodule

// File: tb/tb_t_ram_sdp.sv
// Directed self-checking bench for t_ram_sdp (AW=4, RD_LAT=3); expectations for
// same-address read/write follow T_RAM_SDP_FWD_EN.
module tb_t_ram_sdp;

  logic        clk = 1'b0;
  logic        sys_rst;
  logic        clr_req;
  logic        busy;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [1:0]  wr_be;
  logic [15:0] wr_data;
  logic        rd_en;
  logic [3:0]  rd_addr;
  logic [15:0] rd_data;
  logic        rd_valid;

  int errors = 0;
  int checks = 0;

`ifdef T_RAM_SDP_FWD_EN
  localparam logic [15:0] EXP_RW_FULL = 16'h5555;
  localparam logic [15:0] EXP_RW_PART = 16'hAA55;
`else
  localparam logic [15:0] EXP_RW_FULL = 16'h1111;
  localparam logic [15:0] EXP_RW_PART = 16'h5555;
`endif

  t_ram_sdp #(
    .DW(16), .AW(4), .LANES(2), .RD_LAT(3)
  ) dut (
    .clk     (clk),
    .sys_rst (sys_rst),
    .clr_req (clr_req),
    .busy    (busy),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_be   (wr_be),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .rd_valid(rd_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [15:0] d, input logic [1:0] be);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
    step();
    wr_en = 1'b0; wr_be = 2'b00;
  endtask

  // Steps through a read already set up on the inputs; output appears after edge k+2.
  task automatic read_tail(input logic [15:0] exp, input string tag);
    step();
    rd_en = 1'b0; wr_en = 1'b0; wr_be = 2'b00; clr_req = 1'b0;
    check({tag, "_v_k"}, rd_valid, 0);
    step();
    check({tag, "_v_k1"}, rd_valid, 0);
    step();
    check({tag, "_v"}, rd_valid, 1);
    check({tag, "_d"}, rd_data, exp);
    step();
    check({tag, "_v_after"}, rd_valid, 0);
    check({tag, "_d_after"}, rd_data, 0);
  endtask

  task automatic do_read(input logic [3:0] a, input logic [15:0] exp, input string tag);
    rd_en = 1'b1; rd_addr = a;
    read_tail(exp, tag);
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (busy && n < 40);
  endtask

  initial begin
    int  n;
    logic saw;

    sys_rst = 1'b1; clr_req = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_be = '0; wr_data = '0;
    rd_en = 1'b0; rd_addr = '0;

    // Reset state and power-on sweep
    repeat (3) step();
    check("rst_busy", busy, 1);
    check("rst_valid", rd_valid, 0);
    check("rst_data", rd_data, 0);
    sys_rst = 1'b0;
    wait_idle(n);
    check("rst_sweep_len", n, 16);
    for (int a = 0; a < 16; a++) do_read(4'(a), 16'h0000, $sformatf("zero%0d", a));

    // Byte enables and latency
    do_write(4'd3, 16'hBEEF, 2'b11);
    do_write(4'd3, 16'h1234, 2'b01);
    do_read(4'd3, 16'hBE34, "be");
    do_write(4'd5, 16'h00A5, 2'b11);
    do_read(4'd5, 16'h00A5, "lat");

    // Back-to-back reads
    rd_en = 1'b1; rd_addr = 4'd3;
    step();
    rd_addr = 4'd5;
    step();
    rd_en = 1'b0;
    check("b2b_v0", rd_valid, 0);
    step();
    check("b2b_v1", rd_valid, 1);
    check("b2b_d1", rd_data, 16'hBE34);
    step();
    check("b2b_v2", rd_valid, 1);
    check("b2b_d2", rd_data, 16'h00A5);
    step();
    check("b2b_v3", rd_valid, 0);

    // Same-cycle read and write to one address
    do_write(4'd7, 16'h1111, 2'b11);
    wr_en = 1'b1; wr_addr = 4'd7; wr_data = 16'h5555; wr_be = 2'b11;
    rd_en = 1'b1; rd_addr = 4'd7;
    read_tail(EXP_RW_FULL, "rw_full");
    wr_en = 1'b1; wr_addr = 4'd7; wr_data = 16'hAAAA; wr_be = 2'b10;
    rd_en = 1'b1; rd_addr = 4'd7;
    read_tail(EXP_RW_PART, "rw_part");
    do_read(4'd7, 16'hAA55, "rw_after");

    // Clear request with a same-cycle write; port traffic during busy is dropped
    clr_req = 1'b1; wr_en = 1'b1; wr_addr = 4'd2; wr_data = 16'hFFFF; wr_be = 2'b11;
    step();
    clr_req = 1'b0; wr_en = 1'b0; wr_be = 2'b00;
    check("clr_busy", busy, 1);
    n = 0; saw = 1'b0;
    do begin
      if (n < 8) begin
        clr_req = 1'b1;
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 16'h7777; wr_be = 2'b11;
        rd_en = 1'b1; rd_addr = 4'd3;
      end else begin
        clr_req = 1'b0; wr_en = 1'b0; wr_be = 2'b00; rd_en = 1'b0;
      end
      step();
      n++;
      saw = saw | rd_valid;
    end while (busy && n < 40);
    clr_req = 1'b0; wr_en = 1'b0; wr_be = 2'b00; rd_en = 1'b0;
    check("clr_sweep_len", n, 16);
    repeat (3) begin
      step();
      saw = saw | rd_valid;
    end
    check("busy_no_valid", saw, 0);
    do_read(4'd2, 16'h0000, "clr_a2");
    do_read(4'd3, 16'h0000, "clr_a3");

    // Reset while a read is in flight
    do_write(4'd5, 16'h00A5, 2'b11);
    rd_en = 1'b1; rd_addr = 4'd5;
    step();
    rd_en = 1'b0;
    sys_rst = 1'b1;
    #1;
    check("rdrst_v_now", rd_valid, 0);
    check("rdrst_busy", busy, 1);
    step();
    step();
    check("rdrst_v_late", rd_valid, 0);
    check("rdrst_d_late", rd_data, 0);
    sys_rst = 1'b0;
    wait_idle(n);
    check("rdrst_sweep_len", n, 16);

    // Read in flight across a sweep start, then reset at sweep cycle 8
    do_write(4'd5, 16'h00A5, 2'b11);
    clr_req = 1'b1; rd_en = 1'b1; rd_addr = 4'd5;
    read_tail(16'h00A5, "inflight");
    repeat (5) step();
    check("mid_busy", busy, 1);
    sys_rst = 1'b1;
    #1;
    check("mid_rst_valid", rd_valid, 0);
    step();
    sys_rst = 1'b0;
    wait_idle(n);
    check("mid_sweep_len", n, 16);
    do_read(4'd5, 16'h0000, "mid_a5");
    do_read(4'd7, 16'h0000, "mid_a7");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/t_ram_sdp.md
# t_ram_sdp

Parametrised simple-dual-port scratch RAM for the EKF datapath: one write port with per-lane byte enables and one independent read port with configurable read latency. It replaces the single-port `t_ram` wherever matrix/state buffers need concurrent read and write and a guaranteed-zero array. A built-in clear sequencer zeroes the whole array after reset or on request.

## Interface

- `DW`, 16: data width; must be a multiple of `LANES`.
- `AW`, 4: address width; `DEPTH = 2**AW`.
- `LANES`, 2: number of write-enable lanes; lane width `LW = DW/LANES`.
- `RD_LAT`, 1: read latency in cycles, legal range 1..4.

- `clk`  in  1  sole clock, rising edge.
- `sys_rst`  in  1  asynchronous, active-high reset.
- `clr_req`  in  1  single-cycle request to zero the array.
- `busy`  out  1  clear sweep in progress; port requests are ignored while high.
- `wr_en`  in  1  write strobe.
- `wr_addr`  in  AW  write address.
- `wr_be`  in  LANES  lane enables; bit i covers `wr_data[i*LW +: LW]`.
- `wr_data`  in  DW  write data.
- `rd_en`  in  1  read strobe.
- `rd_addr`  in  AW  read address.
- `rd_data`  out  DW  read data; 0 whenever `rd_valid` is low.
- `rd_valid`  out  1  qualifies `rd_data`, one pulse per accepted read.

## Operation

- FSM states: `CLEAR`, `IDLE`. Sweep counter `clr_cnt` is AW bits wide.
- Reset: FSM enters `CLEAR`, `clr_cnt` = 0, all read-pipeline stages cleared. Reset values: `busy`=1, `rd_valid`=0, `rd_data`=0.
- `CLEAR`: each edge writes 0 to `ram[clr_cnt]` and increments `clr_cnt`. After the edge that writes `DEPTH-1`, the FSM goes to `IDLE`. `busy`=1 throughout.
- `IDLE`: `busy`=0. `clr_req`=1 moves the FSM to `CLEAR` with `clr_cnt`=0.
- `clr_req` is ignored while `busy`=1.
- Write, accepted in `IDLE` only: for each lane with `wr_be[i]`=1, the lane is written. `wr_be`=0 is a no-op.
- Read, accepted in `IDLE` only: `ram[rd_addr]` enters the read pipeline with valid=1. Non-accepted cycles insert valid=0 and data=0.
- Reads already in flight when a sweep starts complete normally.
- Same-cycle `clr_req` and `wr_en` in `IDLE`: the write is performed. The sweep then starts on the next edge and zeroes that location.
- Reset asserted mid-sweep or mid-read: the pipeline is flushed and the sweep restarts from address 0.

## Timing

- Write accepted at edge N; a read of that address accepted at edge N+1 or later returns the new data.
- Read accepted at edge k: `rd_valid`=1 and `rd_data` valid during the cycle after edge k+RD_LAT-1. RD_LAT=1 gives a registered output in the next cycle.
- Full throughput: one read and one write per cycle.
- A sweep takes exactly `DEPTH` cycles. `busy` falls in the cycle after the edge that writes `DEPTH-1`.
- After reset release, `busy` stays 1 for `DEPTH` cycles.

## Configuration

- Macro: `T_RAM_SDP_FWD_EN`. It only affects a read and write accepted on the same edge to the same address.
- Defined: the read returns merged data, with lanes where `wr_be[i]`=1 taking `wr_data` and the other lanes taking the old contents (write-first).
- Undefined: the read returns the old contents (read-first). No bypass mux is built.

## Structure

- Shared package `t_ram_pkg` holds:
  - the FSM state enum (`CLEAR`, `IDLE`);
  - the `RD_LAT` legality bounds;
  - a `depth(aw)` helper constant function.
- Sub-module `t_ram_rd_pipe`: RD_LAT-1 extra register stages for data+valid, asynchronously reset to 0. RD_LAT=1 instantiates zero stages.
- The array, FSM, write lanes and forwarding logic stay in `t_ram_sdp`.

## Test plan

- **Reset sweep:** assert `sys_rst`, then release → `busy` high for 16 cycles (AW=4). Reading every address then returns 0 with `rd_valid` pulses.
- **Byte enables:** write 0xBEEF with `wr_be`=2'b11 to addr 3, then 0x1234 with `wr_be`=2'b01 → a read of addr 3 returns 0xBE34.
- **Latency:** RD_LAT=3, read of addr 5 (holding 0x00A5) at edge k → `rd_valid`=1 and `rd_data`=0x00A5 only in the cycle after edge k+2. `rd_data`=0 elsewhere.
- **Same-cycle read/write:** write 0x5555 to addr 7 (previously 0x1111) and read addr 7 on the same edge → 0x5555 with `T_RAM_SDP_FWD_EN` defined, 0x1111 without.
- **Clear request:**
  - `clr_req` together with a write of 0xFFFF to addr 2 → `busy` goes high for 16 cycles and addr 2 reads 0 afterwards.
  - Writes and reads issued during `busy` are dropped and produce no `rd_valid`.
- **Reset mid-sweep:** `sys_rst` pulse at sweep cycle 8 → `rd_valid`=0 immediately, then a full 16-cycle sweep restarts from addr 0.
